f2i_share_arb: RTL and testbench

//  Round-robin arbiter/sequencer that shares one non-pipelined float2int converter among N_REQ requesters.

---
 rtl/f2i_share_arb_pkg.sv | 10 +
 rtl/f2i_share_arb_if.sv | 29 ++
 rtl/f2i_share_arb_rr_pick.sv | 35 +++
 rtl/f2i_share_arb.sv | 169 ++++++++++++++++
 tb/tb_f2i_share_arb.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/f2i_share_arb_pkg.sv
// Shared types and constants for the float-to-int converter share arbiter.
package f2i_arb_pkg;

  typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT, RESP} state_t;

  localparam logic [31:0] F2I_OVF      = 32'h80000000;
  localparam int unsigned N_REQ_MAX    = 16;
  localparam int unsigned CONV_RST_CYC = 2;

endpackage

// File: rtl/f2i_share_arb_if.sv
// Requester and converter handshake bundle; master is the arbiter's view.
interface f2i_share_arb_if #(
  parameter int unsigned N_REQ = 4
);

  logic [N_REQ*32-1:0] req_a;
  logic [N_REQ-1:0]    req_stb;
  logic [N_REQ-1:0]    req_ack;
  logic [31:0]         rsp_z;
  logic [N_REQ-1:0]    rsp_stb;
  logic [N_REQ-1:0]    rsp_ack;
  logic [31:0]         conv_a;
  logic                conv_a_stb;
  logic                conv_a_ack;
  logic [31:0]         conv_z;
  logic                conv_z_stb;
  logic                conv_z_ack;

  modport master (
    input  req_a, req_stb, rsp_ack, conv_a_ack, conv_z, conv_z_stb,
    output req_ack, rsp_z, rsp_stb, conv_a, conv_a_stb, conv_z_ack
  );

  modport slave (
    output req_a, req_stb, rsp_ack, conv_a_ack, conv_z, conv_z_stb,
    input  req_ack, rsp_z, rsp_stb, conv_a, conv_a_stb, conv_z_ack
  );

endinterface

// File: rtl/f2i_share_arb_rr_pick.sv
// Combinational round-robin picker: lowest index >= ptr with req set, wrapping to 0.
module rr_pick
  import f2i_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   gnt,
  output logic             any
);

  localparam int unsigned IW1 = IDW + 1;

  logic [IW1-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + IW1'(k);
      if (idx >= IW1'(N_REQ)) begin
        idx = idx - IW1'(N_REQ);
      end
      if (req[idx[IDW-1:0]]) begin
        gnt = idx[IDW-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/f2i_share_arb.sv
// Shares one non-pipelined float2int converter among N_REQ requesters, round-robin.
// Optional per-requester grant counters and overflow flag under F2I_ARB_PERF_EN.
module f2i_share_arb
  import f2i_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
`ifdef F2I_ARB_PERF_EN
  parameter  int unsigned PCW   = 16,
`endif
  localparam int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  f2i_share_arb_if.master        bus,
  output logic                   conv_rst,
`ifdef F2I_ARB_PERF_EN
  output logic [N_REQ*PCW-1:0]   perf_cnt,
  output logic                   perf_ovf,
`endif
  output logic                   busy
);

  localparam int unsigned RCW = $clog2(CONV_RST_CYC + 1);

  state_t           state_q;
  logic [IDW-1:0]   rr_q;
  logic [IDW-1:0]   gnt_q;
  logic [IDW-1:0]   pick_gnt;
  logic             pick_any;
  logic [31:0]      a_sel;
  logic [31:0]      a_q;
  logic [31:0]      conv_a_q;
  logic [31:0]      z_q;
  logic [N_REQ-1:0] req_ack_q;
  logic [N_REQ-1:0] rsp_stb_q;
  logic [N_REQ-1:0] gnt_oh;
  logic             conv_a_stb_q;
  logic             conv_z_ack_q;
  logic             busy_q;
  logic             rsp_xfer;
  logic [RCW-1:0]   rst_cnt_q;
  logic [RCW-1:0]   rst_cnt_inc;
  logic             conv_rst_q;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req (bus.req_stb),
    .ptr (rr_q),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  always_comb begin
    a_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt == IDW'(i)) begin
        a_sel = bus.req_a[32*i +: 32];
      end
    end
  end

  assign gnt_oh   = N_REQ'(1) << gnt_q;
  // rsp_stb_q is one-hot on the granted requester, so other rsp_ack bits are masked off.
  assign rsp_xfer = |(rsp_stb_q & bus.rsp_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      gnt_q        <= '0;
      a_q          <= '0;
      conv_a_q     <= '0;
      z_q          <= '0;
      req_ack_q    <= '0;
      rsp_stb_q    <= '0;
      conv_a_stb_q <= 1'b0;
      conv_z_ack_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_any && !conv_rst_q) begin
            gnt_q     <= pick_gnt;
            a_q       <= a_sel;
            req_ack_q <= N_REQ'(1) << pick_gnt;
            busy_q    <= 1'b1;
            state_q   <= GRANT;
          end
        end
        GRANT: begin
          req_ack_q    <= '0;
          conv_a_q     <= a_q;
          conv_a_stb_q <= 1'b1;
          state_q      <= SEND;
        end
        SEND: begin
          if (conv_a_stb_q && bus.conv_a_ack) begin
            conv_a_stb_q <= 1'b0;
            conv_z_ack_q <= 1'b1;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (bus.conv_z_stb && conv_z_ack_q) begin
            z_q          <= bus.conv_z;
            conv_z_ack_q <= 1'b0;
            rsp_stb_q    <= gnt_oh;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (rsp_xfer) begin
            rsp_stb_q <= '0;
            rr_q      <= (gnt_q == IDW'(N_REQ - 1)) ? '0 : gnt_q + IDW'(1);
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Converter reset is held through reset and for CONV_RST_CYC cycles after release.
  assign rst_cnt_inc = rst_cnt_q + RCW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt_q  <= '0;
      conv_rst_q <= 1'b1;
    end else if (conv_rst_q) begin
      rst_cnt_q  <= rst_cnt_inc;
      conv_rst_q <= (rst_cnt_inc != RCW'(CONV_RST_CYC));
    end
  end

  assign bus.req_ack    = req_ack_q;
  assign bus.rsp_z      = z_q;
  assign bus.rsp_stb    = rsp_stb_q;
  assign bus.conv_a     = conv_a_q;
  assign bus.conv_a_stb = conv_a_stb_q;
  assign bus.conv_z_ack = conv_z_ack_q;
  assign conv_rst       = conv_rst_q;
  assign busy           = busy_q;

`ifdef F2I_ARB_PERF_EN
  logic [N_REQ-1:0][PCW-1:0] perf_q;
  logic                      perf_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q     <= '0;
      perf_ovf_q <= 1'b0;
    end else begin
      if (state_q == GRANT && perf_q[gnt_q] != '1) begin
        perf_q[gnt_q] <= perf_q[gnt_q] + PCW'(1);
      end
      if (state_q == WAIT && bus.conv_z_stb && conv_z_ack_q && bus.conv_z == F2I_OVF) begin
        perf_ovf_q <= 1'b1;
      end
    end
  end

  assign perf_cnt = perf_q;
  assign perf_ovf = perf_ovf_q;
`endif

endmodule

// File: tb/tb_f2i_share_arb.sv
// Directed bench for f2i_share_arb with a behavioural stalling float2int converter.
module tb_f2i_share_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic conv_rst;
  logic busy;
  int   total = 0;
  int   bad = 0;
  int   overlap = 0;

  f2i_share_arb_if #(.N_REQ(4)) bus ();

`ifdef F2I_ARB_PERF_EN
  logic [63:0] perf_cnt;
  logic        perf_ovf;
`endif

  f2i_share_arb #(
    .N_REQ (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .conv_rst (conv_rst),
`ifdef F2I_ARB_PERF_EN
    .perf_cnt (perf_cnt),
    .perf_ovf (perf_ovf),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f2i(input logic [31:0] f);
    int          e;
    logic [31:0] m;
    e = int'(f[30:23]) - 127;
    if (f[30:23] == 8'hFF || e >= 31) return 32'h80000000;
    if (e < 0) return 32'h0;
    m = {8'd0, 1'b1, f[22:0]};
    if (e >= 23) m = m << (e - 23);
    else m = m >> (23 - e);
    return f[31] ? -m : m;
  endfunction

  // Non-pipelined converter with a random 0..3 cycle compute stall.
  logic [1:0]  cv_st = 2'd0;
  int          cv_cnt = 0;
  logic [31:0] cv_a = 32'h0;

  always @(posedge clk) begin
    if (conv_rst) begin
      cv_st          <= 2'd0;
      bus.conv_a_ack <= 1'b0;
      bus.conv_z_stb <= 1'b0;
      bus.conv_z     <= 32'h0;
    end else begin
      case (cv_st)
        2'd0: begin
          if (bus.conv_a_stb && bus.conv_a_ack) begin
            bus.conv_a_ack <= 1'b0;
            cv_a           <= bus.conv_a;
            cv_cnt         <= int'($urandom_range(3, 0));
            cv_st          <= 2'd1;
          end else if (bus.conv_a_stb) begin
            bus.conv_a_ack <= 1'b1;
          end
        end
        2'd1: begin
          if (cv_cnt == 0) begin
            bus.conv_z     <= f2i(cv_a);
            bus.conv_z_stb <= 1'b1;
            cv_st          <= 2'd2;
          end else begin
            cv_cnt <= cv_cnt - 1;
          end
        end
        default: begin
          if (bus.conv_z_stb && bus.conv_z_ack) begin
            bus.conv_z_stb <= 1'b0;
            cv_st          <= 2'd0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) if (bus.conv_a_stb && bus.conv_z_ack) overlap++;

  task automatic wait_grant(output logic [3:0] g, output bit ok);
    ok = 1'b0;
    g  = 4'h0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.req_ack != 4'h0) begin
        g  = bus.req_ack;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input logic [1:0] i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.rsp_stb[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called at the negedge where req_ack is seen; holds req_stb across the GRANT edge.
  task automatic finish_xfer(input logic [1:0] i, output logic [31:0] z, output logic [3:0] rs,
                             output logic [3:0] ack_after, output bit ok);
    @(negedge clk);
    ack_after      = bus.req_ack;
    bus.req_stb[i] = 1'b0;
    wait_rsp(i, ok);
    z  = bus.rsp_z;
    rs = bus.rsp_stb;
    bus.rsp_ack[i] = 1'b1;
    @(negedge clk);
    bus.rsp_ack[i] = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.req_ack, bus.rsp_stb, bus.conv_a_stb, bus.conv_z_ack, busy} !== 11'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {bus.req_ack, bus.rsp_stb, bus.conv_a_stb, bus.conv_z_ack, busy});
    end
    total++;
    if ({bus.rsp_z, bus.conv_a} !== 64'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {bus.rsp_z, bus.conv_a});
    end
    total++;
    if (conv_rst !== 1'b1) begin
      bad++;
      $display("FAIL reset_conv_rst: got %b want 1", conv_rst);
    end
    bus.req_a[31:0] = 32'h3F800000;
    bus.req_stb[0]  = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({conv_rst, bus.req_ack} !== 5'b1_0000) begin
      bad++;
      $display("FAIL conv_rst_hold1: got %b want 10000", {conv_rst, bus.req_ack});
    end
    @(negedge clk);
    total++;
    if ({conv_rst, bus.req_ack} !== 5'b0_0000) begin
      bad++;
      $display("FAIL conv_rst_hold2: got %b want 00000", {conv_rst, bus.req_ack});
    end
  endtask

  task automatic test_single;
    logic [3:0] g, rs, aa;
    logic [31:0] z;
    bit ok;
    wait_grant(g, ok);
    total++;
    if (!ok || g !== 4'b0001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: got %b busy %b want 0001 busy 1", g, busy);
    end
    finish_xfer(2'd0, z, rs, aa, ok);
    total++;
    if (aa !== 4'b0000) begin
      bad++;
      $display("FAIL single_ack_pulse: got %b want 0000", aa);
    end
    total++;
    if (!ok || z !== 32'h00000001 || rs !== 4'b0001) begin
      bad++;
      $display("FAIL single_rsp: got z=%h stb=%b want z=00000001 stb=0001", z, rs);
    end
    total++;
    if ({busy, bus.rsp_stb} !== 5'b0) begin
      bad++;
      $display("FAIL single_idle: got %b want 00000", {busy, bus.rsp_stb});
    end
  endtask

  task automatic test_overflow_zero;
    logic [3:0] g, rs, aa;
    logic [31:0] z;
    bit ok;
    bus.req_a[95:64] = 32'h4F32D05E;
    bus.req_stb[2]   = 1'b1;
    wait_grant(g, ok);
    finish_xfer(2'd2, z, rs, aa, ok);
    total++;
    if (g !== 4'b0100 || !ok || z !== 32'h80000000 || rs !== 4'b0100) begin
      bad++;
      $display("FAIL overflow: got g=%b z=%h stb=%b want g=0100 z=80000000 stb=0100", g, z, rs);
    end
    bus.req_a[127:96] = 32'h00000000;
    bus.req_stb[3]    = 1'b1;
    wait_grant(g, ok);
    finish_xfer(2'd3, z, rs, aa, ok);
    total++;
    if (g !== 4'b1000 || !ok || z !== 32'h0 || rs !== 4'b1000) begin
      bad++;
      $display("FAIL zero: got g=%b z=%h stb=%b want g=1000 z=00000000 stb=1000", g, z, rs);
    end
  endtask

  task automatic test_all_four;
    logic [3:0] g, rs, aa;
    logic [31:0] z;
    bit ok;
    for (int k = 0; k < 4; k++) bus.req_a[32*k +: 32] = 32'hC0200000;
    bus.req_stb = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g, ok);
      total++;
      if (!ok || g !== 4'(1 << k)) begin
        bad++;
        $display("FAIL all4_order[%0d]: got %b want %b", k, g, 4'(1 << k));
      end
      finish_xfer(2'(k), z, rs, aa, ok);
      total++;
      if (!ok || z !== 32'hFFFFFFFE || rs !== 4'(1 << k)) begin
        bad++;
        $display("FAIL all4_rsp[%0d]: got z=%h stb=%b want z=FFFFFFFE", k, z, rs);
      end
    end
  endtask

  task automatic test_wrap;
    logic [3:0] g, rs, aa;
    logic [31:0] z;
    bit ok;
    bus.req_a[63:32] = 32'h40000000;
    bus.req_stb[1]   = 1'b1;
    wait_grant(g, ok);
    finish_xfer(2'd1, z, rs, aa, ok);
    total++;
    if (g !== 4'b0010 || !ok || z !== 32'h2) begin
      bad++;
      $display("FAIL wrap_setup: got g=%b z=%h want g=0010 z=00000002", g, z);
    end
    bus.req_a[63:32]  = 32'h3F800000;
    bus.req_a[127:96] = 32'h40A00000;
    bus.req_stb       = 4'b1010;
    wait_grant(g, ok);
    finish_xfer(2'd3, z, rs, aa, ok);
    total++;
    if (g !== 4'b1000 || !ok || z !== 32'h5) begin
      bad++;
      $display("FAIL wrap_first: got g=%b z=%h want g=1000 z=00000005", g, z);
    end
    wait_grant(g, ok);
    finish_xfer(2'd1, z, rs, aa, ok);
    total++;
    if (g !== 4'b0010 || !ok || z !== 32'h1) begin
      bad++;
      $display("FAIL wrap_second: got g=%b z=%h want g=0010 z=00000001", g, z);
    end
  endtask

  task automatic test_hold_rsp;
    logic [3:0] g, rs, aa;
    logic [31:0] z;
    bit ok;
    int unstable;
    bus.req_a[63:32] = 32'h42F6E979;
    bus.req_stb[1]   = 1'b1;
    wait_grant(g, ok);
    @(negedge clk);
    bus.req_stb[1]  = 1'b0;
    bus.req_a[31:0] = 32'hC1A40000;
    bus.req_stb[0]  = 1'b1;
    wait_rsp(2'd1, ok);
    total++;
    if (g !== 4'b0010 || !ok || bus.rsp_z !== 32'h0000007B) begin
      bad++;
      $display("FAIL hold_rsp: got g=%b z=%h want g=0010 z=0000007b", g, bus.rsp_z);
    end
    bus.rsp_ack[0] = 1'b1;
    unstable = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.rsp_stb !== 4'b0010 || bus.rsp_z !== 32'h7B || busy !== 1'b1 ||
          bus.req_ack !== 4'b0) unstable++;
    end
    total++;
    if (unstable != 0) begin
      bad++;
      $display("FAIL hold_stable: got %0d unstable cycles want 0", unstable);
    end
    bus.rsp_ack[0] = 1'b0;
    bus.rsp_ack[1] = 1'b1;
    @(negedge clk);
    bus.rsp_ack[1] = 1'b0;
    wait_grant(g, ok);
    finish_xfer(2'd0, z, rs, aa, ok);
    total++;
    if (g !== 4'b0001 || !ok || z !== 32'hFFFFFFEC) begin
      bad++;
      $display("FAIL hold_next: got g=%b z=%h want g=0001 z=ffffffec", g, z);
    end
  endtask

  task automatic test_reset_in_wait;
    logic [3:0] g, rs, aa;
    logic [31:0] z;
    bit ok;
    bus.req_a[31:0] = 32'h41200000;
    bus.req_stb[0]  = 1'b1;
    wait_grant(g, ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.conv_z_ack) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok || g !== 4'b0001) begin
      bad++;
      $display("FAIL rst_reach_wait: got ok=%b g=%b want ok=1 g=0001", ok, g);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.req_ack, bus.rsp_stb, bus.conv_a_stb, bus.conv_z_ack, busy, conv_rst} !== 12'h001) begin
      bad++;
      $display("FAIL rst_async_clear: got %h want 001",
               {bus.req_ack, bus.rsp_stb, bus.conv_a_stb, bus.conv_z_ack, busy, conv_rst});
    end
    bus.req_a[31:0] = 32'h40490FDB;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({conv_rst, bus.req_ack, bus.rsp_stb} !== 9'b1_0000_0000) begin
      bad++;
      $display("FAIL rst_hold1: got %b want 100000000", {conv_rst, bus.req_ack, bus.rsp_stb});
    end
    @(negedge clk);
    total++;
    if ({conv_rst, bus.req_ack, bus.rsp_stb} !== 9'b0) begin
      bad++;
      $display("FAIL rst_hold2: got %b want 000000000", {conv_rst, bus.req_ack, bus.rsp_stb});
    end
    wait_grant(g, ok);
    finish_xfer(2'd0, z, rs, aa, ok);
    total++;
    if (g !== 4'b0001 || !ok || z !== 32'h3 || rs !== 4'b0001) begin
      bad++;
      $display("FAIL rst_new_req: got g=%b z=%h want g=0001 z=00000003", g, z);
    end
    total++;
    if (overlap != 0) begin
      bad++;
      $display("FAIL conv_overlap: got %0d want 0", overlap);
    end
  endtask

  initial begin
    bus.req_a   = '0;
    bus.req_stb = '0;
    bus.rsp_ack = '0;
    test_reset();
    test_single();
    test_overflow_zero();
    test_all_four();
    test_wrap();
    test_hold_rsp();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
